shift_req_arbiter: RTL
======================

Name: shift_req_arbiter

Overview:
- Shares one 16-bit barrel shifter instance (modes SLL/SRA/ROR, 4-bit amount) between two requesters, e.g. the execute-stage ALU path and a load-alignment path.
- Arbitrates between the two with a round-robin policy and registers the selected operands.
- Drives the shifter's input, mode and amount pins from those registers, captures the shifter's combinational result and returns it with the requester ID over a valid/ready response channel.
- Counts completed operations for performance monitoring.

Parameters:
- RR_INIT, 0: requester that wins the first simultaneous-request tie after reset (0 or 1).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_data  in  16  requester 0 value to shift
- req0_mode  in  2  requester 0 mode: 00 SLL, 01 SRA, 10 ROR, 11 reserved
- req0_amt  in  4  requester 0 shift amount, 0..15
- req1_valid, req1_ready, req1_data, req1_mode, req1_amt: same as requester 0, for requester 1
- sh_in  out  16  to shifter data input
- sh_mode  out  2  to shifter mode input
- sh_amt  out  4  to shifter amount input
- sh_out  in  16  from shifter result (combinational)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  16  shift result
- resp_id  out  1  requester that owns the result
- resp_err  out  1  operation used reserved mode 11
- op_count  out  CNT_W  completed responses; saturates at all-ones

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE; rr_ptr=RR_INIT.
  - Operand registers = 0, so sh_in=0, sh_mode=00, sh_amt=0.
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0, op_count=0.
  - req0_ready=0, req1_ready=0.
  - Reset mid-operation discards the in-flight operation with no response; rr_ptr returns to RR_INIT.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule:
    - Only one reqN_valid asserted -> that requester wins.
    - Both asserted -> requester rr_ptr wins.
  - The winner's reqN_ready is asserted combinationally in the same cycle (accept = valid & ready). The loser's ready stays 0.
  - On accept: register data/mode/amt, register grant ID into resp_id, go to EXEC.
  - No valid -> stay in IDLE.
- EXEC:
  - sh_in/sh_mode/sh_amt are driven from the operand registers.
  - At the clock edge: resp_data<=sh_out, resp_err<=(mode==11), resp_valid<=1, go to RESP.
  - Both reqN_ready = 0.
- RESP:
  - resp_valid=1; resp_data, resp_id and resp_err are held stable until the handshake.
  - On resp_valid & resp_ready:
    - resp_valid<=0 and go to IDLE.
    - rr_ptr<=~resp_id, so the other requester gets priority next.
    - op_count increments unless already all-ones.
  - resp_ready low -> stay in RESP indefinitely.
  - Both reqN_ready = 0.
- Latency: accept in cycle N -> resp_valid high in cycle N+2. Best-case throughput is one operation per 3 cycles.
- Operand registers change only on accept. The shifter inputs are therefore stable from EXEC through RESP.
- Reserved mode 11: forwarded unchanged to the shifter, which passes data through unshifted. resp_data = original data, resp_err=1.
- Amount 0: result equals the input for every mode; resp_err=0 unless mode=11.
- Requester inputs are sampled only in the cycle of accept. A requester must hold valid and its operands until it sees ready.
- No output may be X after reset.

Test Plan:
- Reset, req0 SLL data=0x0001 amt=4, resp_ready=1 -> req0_ready pulses at cycle N; resp_valid at N+2 with resp_data=0x0010, resp_id=0, resp_err=0; op_count=1.
- req1 SRA data=0x8000 amt=3, then req1 ROR data=0x1234 amt=4 -> responses 0xF000 then 0x4123, both resp_id=1; ROR 0x00FF amt=8 -> 0xFF00.
- RR_INIT=0, both valid continuously with distinct operands -> grant order 0,1,0,1 across four responses; resp_id alternates; loser's ready never asserts with the winner's.
- resp_ready held low 5 cycles in RESP -> resp_valid, resp_data and resp_id held constant; no new accept; op_count increments once when resp_ready rises.
- req0 mode=11 data=0xABCD amt=7 -> resp_data=0xABCD, resp_err=1; the next legal op returns resp_err=0.
- rst_n low for one cycle during EXEC -> no resp_valid; all outputs 0, op_count=0; the next simultaneous request is granted to RR_INIT.

Source files
------------

// File: rtl/shift_req_arbiter_if.sv
// Request, shifter and response signals of the shared-shifter arbiter.
// slave is the arbiter side; master is the requesters, shifter and consumer.
interface shift_req_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned AMT_W  = 4;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [MODE_W-1:0] req0_mode;
    logic [AMT_W-1:0]  req0_amt;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [MODE_W-1:0] req1_mode;
    logic [AMT_W-1:0]  req1_amt;

    logic [DATA_W-1:0] sh_in;
    logic [MODE_W-1:0] sh_mode;
    logic [AMT_W-1:0]  sh_amt;
    logic [DATA_W-1:0] sh_out;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;
    logic              resp_err;
    logic [CNT_W-1:0]  op_count;

    modport slave (
        input  req0_valid, req0_data, req0_mode, req0_amt,
        input  req1_valid, req1_data, req1_mode, req1_amt,
        input  sh_out, resp_ready,
        output req0_ready, req1_ready,
        output sh_in, sh_mode, sh_amt,
        output resp_valid, resp_data, resp_id, resp_err, op_count
    );

    modport master (
        output req0_valid, req0_data, req0_mode, req0_amt,
        output req1_valid, req1_data, req1_mode, req1_amt,
        output sh_out, resp_ready,
        input  req0_ready, req1_ready,
        input  sh_in, sh_mode, sh_amt,
        input  resp_valid, resp_data, resp_id, resp_err, op_count
    );
endinterface

// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// returning results over a valid/ready channel and counting completions.
module shift_req_arbiter #(
    parameter bit          RR_INIT = 1'b0,
    parameter int unsigned CNT_W   = 16
) (
    input logic                clk,
    input logic                rst_n,
    shift_req_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned AMT_W  = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    logic [DATA_W-1:0] op_data;
    logic [MODE_W-1:0] op_mode;
    logic [AMT_W-1:0]  op_amt;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;
    logic              resp_err;
    logic [CNT_W-1:0]  op_count;

    logic              grant_c;
    logic              ready0_c;
    logic              ready1_c;
    logic              accept_c;
    logic              resp_fire_c;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grant goes to the lone requester, or to rr_ptr on a tie.
    always_comb begin
        state_nxt = state;
        ready0_c  = 1'b0;
        ready1_c  = 1'b0;
        grant_c   = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
        case (state)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_nxt = EXEC;
                    ready0_c  = ~grant_c;
                    ready1_c  = grant_c;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept_c    = ready0_c | ready1_c;
    assign resp_fire_c = resp_valid & bus.resp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= RR_INIT;
            op_data    <= '0;
            op_mode    <= '0;
            op_amt     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept_c) begin
                op_data <= grant_c ? bus.req1_data : bus.req0_data;
                op_mode <= grant_c ? bus.req1_mode : bus.req0_mode;
                op_amt  <= grant_c ? bus.req1_amt  : bus.req0_amt;
                resp_id <= grant_c;
            end
            if (state == EXEC) begin
                resp_data  <= bus.sh_out;
                resp_err   <= (op_mode == 2'b11);
                resp_valid <= 1'b1;
            end
            // Completion hands priority to the other requester.
            if (resp_fire_c) begin
                resp_valid <= 1'b0;
                rr_ptr     <= ~resp_id;
                if (op_count != '1) op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.sh_in      = op_data;
    assign bus.sh_mode    = op_mode;
    assign bus.sh_amt     = op_amt;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data;
    assign bus.resp_id    = resp_id;
    assign bus.resp_err   = resp_err;
    assign bus.op_count   = op_count;
endmodule
